// File: rtl/alu_writeback.sv
// Writeback sequencer behind the ALU: retires one result bundle per accept and
// drives the register-file write port, splitting 64-bit multiplies into two writes.
module alu_writeback #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        control,
  input  logic [DATA_W-1:0] result_1,
  input  logic [DATA_W-1:0] result_2,
  input  logic              zero_flag,
  input  logic              carry_flag,
  input  logic              sign_flag,
  input  logic              overflow_flag,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wb_en,
  input  logic              flag_en,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [3:0]        status,
  output logic [31:0]       retired
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PAIR = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                w_accept;
  logic                w_is_mul;
  logic                w_start_pair;

  logic                r_rf_we;
  logic [ADDR_W-1:0]   r_rf_waddr;
  logic [DATA_W-1:0]   r_rf_wdata;
  logic [3:0]          r_status;
  logic [31:0]         r_retired;
  logic [ADDR_W-1:0]   r_pend_addr;
  logic [DATA_W-1:0]   r_pend_data;

  assign in_ready     = !rst && (r_state == S_IDLE);
  assign w_accept     = in_valid && in_ready;
  assign w_is_mul     = (control == 4'b1010) || (control == 4'b1011);
  assign w_start_pair = w_accept && w_is_mul && wb_en;

  // NOTE: every signal written in always_comb is given a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_pair) w_state_next = S_PAIR;
      S_PAIR:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_we     <= 1'b0;
      r_rf_waddr  <= '0;
      r_rf_wdata  <= '0;
      r_status    <= 4'b0000;
      r_retired   <= 32'd0;
      r_pend_addr <= '0;
      r_pend_data <= '0;
    end else if (r_state == S_PAIR) begin
      r_rf_we    <= (r_pend_addr != '0);
      r_rf_waddr <= r_pend_addr;
      r_rf_wdata <= r_pend_data;
    end else if (w_accept) begin
      r_rf_we    <= wb_en && (rd_addr != '0);
      r_rf_waddr <= rd_addr;
      r_rf_wdata <= result_1;
      r_retired  <= r_retired + 32'd1;
      if (flag_en)
        r_status <= {zero_flag, carry_flag, sign_flag, overflow_flag};
      if (w_start_pair) begin
        // rd=31 wraps to r0, whose write is then suppressed like any r0 write
        r_pend_addr <= rd_addr + ADDR_W'(1);
        r_pend_data <= result_2;
      end
    end else begin
      r_rf_we <= 1'b0;
    end
  end

  assign rf_we    = r_rf_we;
  assign rf_waddr = r_rf_waddr;
  assign rf_wdata = r_rf_wdata;
  assign status   = r_status;
  assign retired  = r_retired;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: a table of single-cycle retires plus
// hand-written multiply, register-0 wrap and reset-in-pair sequences.
module tb_alu_writeback;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        control;
  logic [DATA_W-1:0] result_1;
  logic [DATA_W-1:0] result_2;
  logic              zero_flag, carry_flag, sign_flag, overflow_flag;
  logic [ADDR_W-1:0] rd_addr;
  logic              wb_en;
  logic              flag_en;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [3:0]        status;
  logic [31:0]       retired;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .control(control), .result_1(result_1), .result_2(result_2),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .sign_flag(sign_flag),
    .overflow_flag(overflow_flag), .rd_addr(rd_addr), .wb_en(wb_en),
    .flag_en(flag_en), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .status(status), .retired(retired)
  );

  typedef struct {
    logic [3:0]        ctrl;
    logic [DATA_W-1:0] r1;
    logic [DATA_W-1:0] r2;
    logic [ADDR_W-1:0] rd;
    logic              wb;
    logic              fe;
    logic [3:0]        flags;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_waddr;
    logic [DATA_W-1:0] exp_wdata;
    logic [3:0]        exp_status;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic [DATA_W-1:0] r1,
                       input logic [DATA_W-1:0] r2, input logic [ADDR_W-1:0] rd,
                       input logic wb, input logic fe, input logic [3:0] fl);
    in_valid = 1'b1;
    control  = c;
    result_1 = r1;
    result_2 = r2;
    rd_addr  = rd;
    wb_en    = wb;
    flag_en  = fe;
    {zero_flag, carry_flag, sign_flag, overflow_flag} = fl;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    control = '0; result_1 = '0; result_2 = '0; rd_addr = '0;
    wb_en = 1'b0; flag_en = 1'b0;
    {zero_flag, carry_flag, sign_flag, overflow_flag} = 4'b0000;

    // ctrl, r1, r2, rd, wb, fe, flags, exp_we, exp_waddr, exp_wdata, exp_status
    vecs[0] = '{4'b0000, 32'h0000_0005, 32'h0, 5'd3,  1'b1, 1'b1, 4'b0100, 1'b1, 5'd3,  32'h0000_0005, 4'b0100};
    vecs[1] = '{4'b0001, 32'hDEAD_BEEF, 32'h0, 5'd7,  1'b1, 1'b1, 4'b1001, 1'b1, 5'd7,  32'hDEAD_BEEF, 4'b1001};
    vecs[2] = '{4'b0100, 32'h0000_0000, 32'h0, 5'd12, 1'b1, 1'b1, 4'b1010, 1'b1, 5'd12, 32'h0000_0000, 4'b1010};
    vecs[3] = '{4'b0010, 32'h8000_0000, 32'h0, 5'd30, 1'b1, 1'b0, 4'b0111, 1'b1, 5'd30, 32'h8000_0000, 4'b1010};
    vecs[4] = '{4'b0000, 32'h0000_1234, 32'h0, 5'd0,  1'b1, 1'b1, 4'b0001, 1'b0, 5'd0,  32'h0000_1234, 4'b0001};
    vecs[5] = '{4'b0011, 32'h0000_0055, 32'h0, 5'd9,  1'b0, 1'b0, 4'b1111, 1'b0, 5'd9,  32'h0000_0055, 4'b0001};
    vecs[6] = '{4'b1010, 32'h0000_0077, 32'hAAAA, 5'd10, 1'b0, 1'b1, 4'b0010, 1'b0, 5'd10, 32'h0000_0077, 4'b0010};
    vecs[7] = '{4'b1100, 32'h0000_0099, 32'h0, 5'd4,  1'b1, 1'b1, 4'b0000, 1'b1, 5'd4,  32'h0000_0099, 4'b0000};

    // Reset held for two cycles
    step();
    step();
    check("reset rf_we", rf_we, 0);
    check("reset status", status, 0);
    check("reset retired", retired, 0);
    check("reset in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    check("in_ready after release", in_ready, 1);

    // Back-to-back table retires, one accept per cycle
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].ctrl, vecs[i].r1, vecs[i].r2, vecs[i].rd, vecs[i].wb, vecs[i].fe, vecs[i].flags);
      step();
      check($sformatf("vec%0d rf_we", i), rf_we, vecs[i].exp_we);
      check($sformatf("vec%0d rf_waddr", i), rf_waddr, vecs[i].exp_waddr);
      check($sformatf("vec%0d rf_wdata", i), rf_wdata, vecs[i].exp_wdata);
      check($sformatf("vec%0d status", i), status, vecs[i].exp_status);
      check($sformatf("vec%0d retired", i), retired, 64'(i + 1));
      check($sformatf("vec%0d in_ready", i), in_ready, 1);
    end

    // Idle cycle: strobe drops, address and data hold
    in_valid = 1'b0;
    step();
    check("idle rf_we", rf_we, 0);
    check("idle rf_waddr", rf_waddr, 4);
    check("idle rf_wdata", rf_wdata, 32'h99);
    check("idle retired", retired, 8);

    // Unsigned multiply to r8/r9 with a bundle held during the pair cycle
    drive(4'b1010, 32'h1, 32'hFFFF_FFFE, 5'd8, 1'b1, 1'b1, 4'b0100);
    step();
    check("mul hi rf_we", rf_we, 1);
    check("mul hi rf_waddr", rf_waddr, 8);
    check("mul hi rf_wdata", rf_wdata, 32'h1);
    check("mul in_ready low", in_ready, 0);
    check("mul retired at accept", retired, 9);
    check("mul status at accept", status, 4'b0100);
    drive(4'b0000, 32'h42, 32'h0, 5'd5, 1'b1, 1'b0, 4'b1111);
    step();
    check("mul lo rf_we", rf_we, 1);
    check("mul lo rf_waddr", rf_waddr, 9);
    check("mul lo rf_wdata", rf_wdata, 32'hFFFF_FFFE);
    check("held bundle not yet retired", retired, 9);
    check("in_ready after pair", in_ready, 1);
    step();
    check("held rf_we", rf_we, 1);
    check("held rf_waddr", rf_waddr, 5);
    check("held rf_wdata", rf_wdata, 32'h42);
    check("held retired", retired, 10);
    check("held status kept", status, 4'b0100);

    // Signed multiply at r31: second write wraps to r0 and is suppressed
    drive(4'b1011, 32'hCAFE, 32'hBEEF, 5'd31, 1'b1, 1'b0, 4'b0000);
    step();
    in_valid = 1'b0;
    check("wrap hi rf_we", rf_we, 1);
    check("wrap hi rf_waddr", rf_waddr, 31);
    check("wrap hi rf_wdata", rf_wdata, 32'hCAFE);
    step();
    check("wrap lo rf_we", rf_we, 0);
    check("wrap lo rf_waddr", rf_waddr, 0);
    check("wrap lo rf_wdata", rf_wdata, 32'hBEEF);
    check("wrap retired", retired, 11);
    step();
    check("after wrap rf_we", rf_we, 0);

    // Reset during the pair cycle drops the pending write
    drive(4'b1010, 32'h10, 32'h20, 5'd20, 1'b1, 1'b1, 4'b1111);
    step();
    in_valid = 1'b0;
    check("rst-pair hi rf_we", rf_we, 1);
    check("rst-pair in_ready", in_ready, 0);
    check("rst-pair status", status, 4'b1111);
    rst = 1'b1;
    step();
    check("rst-pair rf_we", rf_we, 0);
    check("rst-pair retired", retired, 0);
    check("rst-pair status cleared", status, 0);
    check("rst-pair in_ready in rst", in_ready, 0);
    rst = 1'b0;
    #1;
    check("rst-pair in_ready release", in_ready, 1);
    step();
    check("no r21 write", rf_we, 0);
    check("rst-pair retired stays", retired, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
